// File: rtl/tenyr_alu_pkg.sv
// Shared opcode encodings and execute-unit state encoding for the tenyr ALU.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package tenyr_pkg;

    // tenyr opcodes
    localparam logic [3:0] OP_OR   = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_RSV4 = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_LT   = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_GT   = 4'b1000;
    localparam logic [3:0] OP_ANDN = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_XNOR = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_NE   = 4'b1110;
    localparam logic [3:0] OP_RSVF = 4'b1111;

    // Arithmetic shift right shares the 0100 slot when that build option is on
    localparam logic [3:0] OP_SRA  = OP_RSV4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/tenyr_mul_iter.sv
// Iterative multiplier: retires MUL_BITS multiplier bits per cycle, low WIDTH bits of product.
// Latency: done is high in the cycle WIDTH/MUL_BITS cycles after the start edge.
// Backpressure: none; caller must not restart while busy and must take product on done.
module tenyr_mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int STEPS = WIDTH / MUL_BITS;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             busy;

    // Only the low WIDTH bits are kept, so unsigned partial products are
    // correct for two's-complement operands as well.
    logic [WIDTH-1:0] first_pp;
    logic [WIDTH-1:0] next_pp;
    assign first_pp = multiplicand * WIDTH'(multiplier[MUL_BITS-1:0]);
    assign next_pp  = mcand * WIDTH'(mplier[MUL_BITS-1:0]);

    // The first digit is folded in on the start edge so the result is ready
    // after STEPS-1 further edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= first_pp;
            mcand  <= multiplicand << MUL_BITS;
            mplier <= multiplier >> MUL_BITS;
            cnt    <= CW'(1);
            busy   <= 1'b1;
        end else if (busy) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
            end else begin
                acc    <= acc + next_pp;
                mcand  <= mcand << MUL_BITS;
                mplier <= mplier >> MUL_BITS;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    assign done    = busy && (cnt == LAST);
    assign product = acc;

endmodule

// File: rtl/tenyr_alu.sv
// Handshaked tenyr execute unit: rhs = (X op O) + A; optional SRA on op 0100 via TENYR_ALU_SRA_EN.
// Latency: 1 cycle for non-multiply ops, WIDTH/MUL_BITS + 1 cycles for multiply.
// Backpressure: result held stable until out_ready; in_ready only when idle or result being taken.
module tenyr_alu
    import tenyr_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 12,
    parameter int MUL_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic                 swap,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [IMM_WIDTH-1:0] imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     rhs,
    output logic                 err
);

    localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] i_ext;
    logic [WIDTH-1:0] o_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign i_ext = WIDTH'($signed(imm));
    assign o_sel = swap ? i_ext : y;
    assign a_sel = swap ? y : i_ext;

    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    // Single-cycle result for every op except multiply.
    always_comb begin
        pre     = '0;
        alu_err = 1'b0;
        case (op)
            OP_OR:   pre = x | o_sel;
            OP_AND:  pre = x & o_sel;
            OP_ADD:  pre = x + o_sel;
            OP_MUL:  pre = '0;
            OP_SHL:  pre = (o_sel >= W_LIM) ? '0 : (x << o_sel);
            OP_LT:   pre = ($signed(x) <  $signed(o_sel)) ? '1 : '0;
            OP_EQ:   pre = (x == o_sel) ? '1 : '0;
            OP_GT:   pre = ($signed(x) >  $signed(o_sel)) ? '1 : '0;
            OP_ANDN: pre = x & ~o_sel;
            OP_XOR:  pre = x ^ o_sel;
            OP_SUB:  pre = x - o_sel;
            OP_XNOR: pre = ~(x ^ o_sel);
            OP_SHR:  pre = (o_sel >= W_LIM) ? '0 : (x >> o_sel);
            OP_NE:   pre = (x != o_sel) ? '1 : '0;
`ifdef TENYR_ALU_SRA_EN
            OP_SRA:  pre = (o_sel >= W_LIM) ? {WIDTH{x[WIDTH-1]}}
                                            : WIDTH'($signed(x) >>> o_sel);
`endif
            default: begin
                pre     = '0;
                alu_err = 1'b1;
            end
        endcase
        alu_res = pre + a_sel;
    end

    tenyr_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (mul_start),
        .multiplicand (x),
        .multiplier   (o_sel),
        .done         (mul_done),
        .product      (mul_product)
    );

    // Control FSM with registered result; A is parked in a_q during a multiply
    // so the operand buses may change after accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rhs       <= '0;
            err       <= 1'b0;
            a_q       <= '0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                state     <= MUL;
                out_valid <= 1'b0;
                err       <= 1'b0;
                a_q       <= a_sel;
            end else begin
                state     <= HOLD;
                out_valid <= 1'b1;
                rhs       <= alu_res;
                err       <= alu_err;
            end
        end else if ((state == MUL) && mul_done) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            rhs       <= mul_product + a_q;
            err       <= 1'b0;
        end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tenyr_alu.sv
// Directed-vector bench for tenyr_alu at default parameters.
// Latency: checks 1-cycle ALU ops and 9-cycle multiply.
// Backpressure: exercises out_ready stalls and same-cycle re-accept.
module tb_tenyr_alu;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        swap;
    logic [31:0] x;
    logic [31:0] y;
    logic [11:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rhs;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    tenyr_alu #(
        .WIDTH     (32),
        .IMM_WIDTH (12),
        .MUL_BITS  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .swap      (swap),
        .x         (x),
        .y         (y),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rhs       (rhs),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait (bounded) for acceptance, then scramble operands.
    task automatic issue(input logic [3:0] o, input logic s, input logic [31:0] xv,
                         input logic [31:0] yv, input logic [11:0] iv);
        int guard;
        op = o; swap = s; x = xv; y = yv; imm = iv;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check("issue_timeout", 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        x = 32'hDEAD_BEEF; y = 32'h1234_5678; imm = 12'h5A5; swap = ~s;
    endtask

    // One-cycle op with out_ready high: result must appear right after accept.
    task automatic run1(input string tag, input logic [3:0] o, input logic s,
                        input logic [31:0] xv, input logic [31:0] yv, input logic [11:0] iv,
                        input logic [31:0] exp_rhs, input logic exp_err);
        out_ready = 1'b1;
        issue(o, s, xv, yv, iv);
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_rhs"}, rhs, exp_rhs);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        tick();
    endtask

    initial begin
        int seen;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; swap = 1'b0; x = '0; y = '0; imm = '0;
        #12;
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        check("rst_rhs", rhs, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        reset_n = 1'b1;
        tick();

        // add: O=7, A=-1 -> 11; valid must drop the next cycle
        run1("add", 4'b0010, 1'b0, 32'd5, 32'd7, 12'hFFF, 32'd11, 1'b0);
        check("add_pulse", {31'd0, out_valid}, 32'd0);

        // multiply: -3*1000 + 2 = -2998 after exactly 9 cycles
        out_ready = 1'b1;
        issue(4'b0011, 1'b0, 32'hFFFF_FFFD, 32'd1000, 12'd2);
        for (int k = 1; k <= 8; k++) begin
            check("mul_busy_rdy", {31'd0, in_ready}, 32'd0);
            check("mul_busy_vld", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("mul_vld", {31'd0, out_valid}, 32'd1);
        check("mul_rhs", rhs, 32'hFFFF_F44A);
        check("mul_err", {31'd0, err}, 32'd0);
        tick();

        // signed lt with swap: O=1, A=4, -1<1 -> -1+4 = 3
        run1("lt",   4'b0110, 1'b1, 32'hFFFF_FFFF, 32'd4, 12'd1, 32'd3, 1'b0);
        // shl by O=40 saturates to 0, leaving A
        run1("shl",  4'b0101, 1'b1, 32'hFFFF_FFFF, 32'h0000_0077, 12'd40, 32'h0000_0077, 1'b0);
        run1("shr",  4'b1101, 1'b1, 32'h8000_0000, 32'd0, 12'd4, 32'h0800_0000, 1'b0);
        run1("eq",   4'b0111, 1'b0, 32'd7, 32'd7, 12'd0, 32'hFFFF_FFFF, 1'b0);
        run1("andn", 4'b1001, 1'b0, 32'h0000_00FF, 32'h0000_000F, 12'd0, 32'h0000_00F0, 1'b0);
        run1("gt",   4'b1000, 1'b0, 32'hFFFF_FFFE, 32'd1, 12'd10, 32'd10, 1'b0);
        run1("rsvf", 4'b1111, 1'b1, 32'd123, 32'd9, 12'd3, 32'd9, 1'b1);
`ifdef TENYR_ALU_SRA_EN
        run1("sra",  4'b0100, 1'b1, 32'h8000_0000, 32'h10, 12'd4, 32'hF800_0010, 1'b0);
`else
        run1("rsv4", 4'b0100, 1'b1, 32'h8000_0000, 32'h10, 12'd4, 32'h0000_0010, 1'b1);
`endif

        // backpressure: xor result held for 5 stalled cycles with a sub pending
        out_ready = 1'b0;
        issue(4'b1010, 1'b0, 32'hF0F0_0000, 32'h0FF0_0000, 12'd0);
        check("bp_vld0", {31'd0, out_valid}, 32'd1);
        check("bp_rhs0", rhs, 32'hFF00_0000);
        op = 4'b1011; swap = 1'b0; x = 32'd100; y = 32'd30; imm = 12'd5;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_vld", {31'd0, out_valid}, 32'd1);
            check("bp_rhs", rhs, 32'hFF00_0000);
            check("bp_rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_vld", {31'd0, out_valid}, 32'd1);
        check("b2b_rhs", rhs, 32'd75);
        tick();
        check("b2b_idle", {31'd0, out_valid}, 32'd0);

        // reset mid-multiply, with a nonzero rhs left over from the previous op
        issue(4'b0011, 1'b0, 32'd6, 32'd7, 12'd1);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mrst_vld", {31'd0, out_valid}, 32'd0);
        check("mrst_rhs", rhs, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen++;
            tick();
        end
        check("mrst_stale", seen, 32'd0);
        run1("post_rst_add", 4'b0010, 1'b0, 32'd20, 32'd22, 12'd0, 32'd42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/tenyr_alu.md
Name: tenyr_alu

Overview:
Parametrised, handshaked execution unit for tenyr cores, the successor to the fixed 32-bit, single-cycle-enable execute stage.
- Accepts one operation (op, swap, X, Y, I) per valid/ready transaction and returns rhs = (X op O) + A.
- A = I and O = Y when swap=0; A = Y and O = I when swap=1.
- Multiply runs in an iterative unit with a known latency, so the core no longer needs a padding state.
- Reserved opcodes raise a flag instead of producing X values.

Parameters:
WIDTH, 32, datapath width in bits; must be ≥ 8.
IMM_WIDTH, 12, immediate field width; I is sign-extended to WIDTH.
MUL_BITS, 4, multiplier bits retired per cycle; WIDTH % MUL_BITS == 0.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  unit can accept this cycle
op  in  4  tenyr opcode
swap  in  1  instruction kind bit; selects O/A as in Overview
x  in  WIDTH  X operand, signed
y  in  WIDTH  Y operand, signed
imm  in  IMM_WIDTH  raw immediate
out_valid  out  1  result available
out_ready  in  1  consumer takes result
rhs  out  WIDTH  result
err  out  1  reserved opcode executed; qualified by out_valid

Behaviour:
Reset:
- Asynchronous; state=IDLE, out_valid=0, rhs=0, err=0, multiplier accumulator=0.
- Reset mid-multiply abandons the operation; no result is emitted.

States:
- IDLE: no operation in flight.
- MUL: iterating a multiply.
- HOLD: out_valid=1, waiting for out_ready.

Handshakes:
- in_ready = (state==IDLE) | (state==HOLD & out_ready).
- Accept occurs when in_valid & in_ready on a rising edge. Operands are captured at accept and may change afterwards.

Latency from accept edge:
- Non-multiply ops: result registered on the accept edge itself, so out_valid is high the next cycle (latency 1). Next state is HOLD.
- Multiply (0011): next state is MUL for WIDTH/MUL_BITS cycles, then HOLD. Latency is WIDTH/MUL_BITS + 1 (9 at defaults).

Output stability:
- rhs and err stay stable while out_valid & !out_ready.
- HOLD & out_ready & !in_valid returns to IDLE with out_valid=0.
- Back-to-back non-mul ops sustain one result per cycle.

Arithmetic (all results truncated to WIDTH, two's complement):
- Ops 0000 or, 0001 and, 0010 add, 1001 andn, 1010 xor, 1011 sub, 1100 xnor: (X op O) + A.
- 0011 multiply: low WIDTH bits of X*O, then + A.
- 0101 shl and 1101 shr (logical): O treated as unsigned; O ≥ WIDTH gives 0 before + A.
- 0110 lt, 0111 eq, 1000 gt, 1110 ne: signed comparisons. True contributes all-ones (−1), false contributes 0; then + A.
- 0100 and 1111 (reserved): rhs = A, err=1. err=0 for all other ops.
- Overflow wraps silently.

Optional Feature:
TENYR_ALU_SRA_EN:
- Defined: op 0100 is arithmetic shift right, X >>> O. O ≥ WIDTH yields all sign bits, then + A; err=0.
- Undefined: 0100 is reserved as above.
- 1111 stays reserved in both builds.

Decomposition:
- Package tenyr_pkg holds opcode localparams (OP_OR … OP_NE, OP_RSV4, OP_RSVF) and the state encoding IDLE/MUL/HOLD.
- Sub-module tenyr_mul_iter, parameters WIDTH and MUL_BITS.
  - Ports: start, multiplicand, multiplier; outputs done (one-cycle pulse) and product (low WIDTH bits).
  - tenyr_alu adds A to the product on the done cycle.

Test Plan:
- WIDTH=32: op=0010, swap=0, x=5, y=7, imm=12'hFFF, out_ready=1 → one cycle later rhs=11, err=0, out_valid pulses 1 cycle.
- op=0011, x=−3, y=1000, imm=2, swap=0 → out_valid exactly 9 cycles after accept; rhs=−2998; in_ready=0 during cycles 1–8.
- op=0110, swap=1, x=−1, y=4, imm=1 (O=1, A=4) → rhs=3. Also op=0101, O=40 → rhs=A.
- out_ready held 0 for 5 cycles after a result → rhs and out_valid stable, in_ready=0; releasing out_ready accepts the next op the same cycle.
- op=1111, y=9, swap=1 → rhs=9, err=1. op=0100 → err=1 without the macro; with TENYR_ALU_SRA_EN, x=32'h80000000, O=4 → rhs=32'hF8000000+A.
- Assert reset_n low 3 cycles into a multiply → out_valid=0, rhs=0 immediately; after release, no stale result and the next add completes in 1 cycle.
